// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam logic [31:0] IF_NOP              = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET,
        FETCH,
        DRAIN
    } if_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush; DEPTH is a power of two.
module if_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  if_entry_t     entry_i,
    input  logic          pop_i,
    output if_entry_t     head_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited in-order fetch, response queue, redirect/drain.
// Optional IF_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IF_RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] instrucao,
    output logic [31:0] id_pc
);

    localparam int unsigned CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

    if_state_t     state_q, state_d;
    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0] out_q, out_d, stale_q, stale_d, q_count;
    logic [CW:0]   used;
    logic          req_fire, rsp_live, q_valid, q_push, q_pop, byp_valid, byp_take;
    if_entry_t     q_head, rsp_entry;

    assign redir_pc  = redirect_pc & ~32'h3;
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_live  = imem_resp_valid & (stale_q == '0) & ~redirect_valid;
    assign q_valid   = (q_count != '0);
    assign q_pop     = q_valid & id_ready & ~redirect_valid;
`ifdef IF_BYPASS_EN
    assign byp_valid = rsp_live & ~q_valid;
`else
    assign byp_valid = 1'b0;
`endif
    assign byp_take  = byp_valid & id_ready;
    assign q_push    = rsp_live & ~byp_take;
    assign rsp_entry = '{instr: imem_resp_data, pc: rsp_pc_q};

    // A slot released by this cycle's consume can be re-requested now; this keeps 1/cycle with depth 2.
    assign used = {1'b0, out_q} + {1'b0, q_count} - (CW + 1)'(q_pop | byp_take);

    if_queue #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (q_push),
        .entry_i (rsp_entry),
        .pop_i   (q_pop),
        .head_o  (q_head),
        .count_o (q_count)
    );

    always_comb begin
        out_d   = out_q + CW'(req_fire) - CW'(imem_resp_valid);
        stale_d = stale_q;
        if (redirect_valid) begin
            stale_d = out_d;
        end else if (imem_resp_valid && stale_q != '0) begin
            stale_d = stale_q - CW'(1);
        end
        pc_d     = redirect_valid ? redir_pc : (req_fire ? pc_q + 32'd4 : pc_q);
        rsp_pc_d = redirect_valid ? redir_pc : (rsp_live ? rsp_pc_q + 32'd4 : rsp_pc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = FETCH;
            FETCH:   if (redirect_valid && stale_d != '0) state_d = DRAIN;
            DRAIN:   if (stale_d == '0) state_d = FETCH;
            default: state_d = RESET;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == FETCH) && (used < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            stale_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            stale_q  <= stale_d;
        end
    end

    assign imem_req_addr = pc_q;

    always_comb begin
        id_valid  = q_valid | byp_valid;
        instrucao = IF_NOP;
        id_pc     = '0;
        if (q_valid) begin
            instrucao = q_head.instr;
            id_pc     = q_head.pc;
        end else if (byp_valid) begin
            instrucao = imem_resp_data;
            id_pc     = rsp_pc_q;
        end
    end

endmodule
